// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder: select/mode controls in, one-hot word and index out.
interface onehot_scan_decoder_if #(
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] s;
    logic [OUT_W-1:0] a;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, load, s,
        input  a, idx, wrap
    );

    modport slave (
        input  en, mode, load, s,
        output a, idx, wrap
    );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with an auto-scan mode that walks the set bit
// through all outputs, dwelling DWELL enabled cycles per output and pulsing wrap on rollover.
module onehot_scan_decoder #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_scan_decoder_if.slave   bus
);
    localparam int unsigned OUT_W   = 2 ** SEL_W;
    localparam int unsigned DW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX   = SEL_W'(OUT_W - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] idx_q,   idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [OUT_W-1:0] a_q,     a_d;
    logic             wrap_q,  wrap_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            a_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            a_q     <= a_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: direct/load jump, activation, scan step, dwell count
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;

        if (bus.en) begin
            state_d = ST_RUN;
            if (!bus.mode || bus.load) begin
                idx_d   = bus.s;
                dwell_d = '0;
            end else if (state_q == ST_IDLE) begin
                // First enabled scan edge only lights the current index.
                dwell_d = '0;
            end else if (dwell_q == DWELL_MAX) begin
                idx_d   = idx_q + SEL_W'(1);
                dwell_d = '0;
                wrap_d  = (idx_q == IDX_MAX);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end

        a_d = (state_d == ST_RUN) ? (OUT_W'(1) << idx_d) : '0;
    end

    assign bus.a    = a_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench for onehot_scan_decoder: directed scenarios plus randomized traffic
// checked against a phase-counting reference model.
module tb_onehot_scan_decoder;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DWELL = 4;
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic clk = 1'b0;
    logic rst_n;

    onehot_scan_decoder_if #(.SEL_W(SEL_W)) bus ();

    onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index is anchor advanced by one per DWELL enabled scan cycles.
    bit m_active;
    bit m_wrap;
    int m_anchor;
    int m_phase;

    function automatic int m_idx();
        return (m_anchor + m_phase / DWELL) % OUT_W;
    endfunction

    function automatic logic [31:0] m_a();
        return m_active ? (32'd1 << m_idx()) : 32'd0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_wrap   = 1'b0;
        m_anchor = 0;
        m_phase  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("a_model",    32'(bus.a),    m_a());
        check("idx_model",  32'(bus.idx),  32'(m_idx()));
        check("wrap_model", 32'(bus.wrap), 32'(m_wrap));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (bus.en) begin
            if (!m_active || !bus.mode || bus.load) begin
                m_anchor = (!bus.mode || bus.load) ? int'(bus.s) : m_idx();
                m_phase  = 0;
                m_active = 1'b1;
                m_wrap   = 1'b0;
            end else begin
                m_phase++;
                m_wrap = ((m_phase % DWELL) == 0) && (m_idx() == 0);
            end
        end else begin
            m_wrap = 1'b0;
        end
        #1;
        check_model();
    endtask

    task automatic drive(input logic en, input logic mode, input logic load, input int s);
        bus.en   = en;
        bus.mode = mode;
        bus.load = load;
        bus.s    = SEL_W'(s);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1, 0, 0, 5);

        // Reset holds outputs at zero despite active inputs
        repeat (2) @(posedge clk);
        #1;
        check("rst_a",    32'(bus.a),    32'h00);
        check("rst_idx",  32'(bus.idx),  32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_a",   32'(bus.a),   32'h20);
        check("rel_idx", 32'(bus.idx), 32'd5);

        // Direct sweep
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, i);
            tick();
            check("dir_a",    32'(bus.a),    32'd1 << i);
            check("dir_wrap", 32'(bus.wrap), 32'd0);
        end

        // Scan from 6 through the wrap
        drive(1, 1, 1, 6);
        tick();
        check("scan_load_a", 32'(bus.a), 32'h40);
        drive(1, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 4)       check("scan_hold6", 32'(bus.a), 32'h40);
            else if (i < 8)  check("scan_hold7", 32'(bus.a), 32'h80);
            else begin
                check("scan_wrap_a",    32'(bus.a),    32'h01);
                check("scan_wrap_flag", 32'(bus.wrap), 32'd1);
            end
            if (i != 8) check("scan_nowrap", 32'(bus.wrap), 32'd0);
        end
        for (int i = 1; i <= 32; i++) tick();
        check("period_a",    32'(bus.a),    32'h01);
        check("period_wrap", 32'(bus.wrap), 32'd1);

        // Enable freeze at dwell 2
        repeat (2) tick();
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_a",    32'(bus.a),    32'h01);
            check("frz_wrap", 32'(bus.wrap), 32'd0);
        end
        drive(1, 1, 0, 0);
        tick();
        check("frz_post1", 32'(bus.a), 32'h01);
        tick();
        check("frz_step", 32'(bus.a), 32'h02);

        // Load colliding with a step at idx 7
        drive(1, 1, 1, 7);
        tick();
        drive(1, 1, 0, 0);
        repeat (3) tick();
        drive(1, 1, 1, 2);
        tick();
        check("col_a",    32'(bus.a),    32'h04);
        check("col_idx",  32'(bus.idx),  32'd2);
        check("col_wrap", 32'(bus.wrap), 32'd0);
        drive(1, 1, 0, 0);
        repeat (3) tick();
        check("col_hold", 32'(bus.a), 32'h04);
        tick();
        check("col_step", 32'(bus.a), 32'h08);

        // Asynchronous reset mid-scan
        drive(1, 1, 1, 4);
        tick();
        drive(1, 1, 0, 0);
        repeat (2) tick();
        check("ar_pre", 32'(bus.a), 32'h10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar_async_a",   32'(bus.a),   32'h00);
        check("ar_async_idx", 32'(bus.idx), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_first", 32'(bus.a), 32'h01);
        repeat (3) tick();
        check("ar_hold", 32'(bus.a), 32'h01);
        tick();
        check("ar_step", 32'(bus.a), 32'h02);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, OUT_W - 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder with an auto-scan mode. It is the clocked successor to the team's combinational 3-to-8 decoder. In direct mode it decodes a select input to a one-hot output word with one cycle of latency. In scan mode it walks the one-hot bit through all outputs itself, dwelling a programmable number of cycles per output, and flags each wrap-around. It drives row/digit strobes and channel-enable fan-outs.

## Interface
- SEL_W, 3, select width; must be >= 1.
- OUT_W, 2**SEL_W, one-hot output width; fixed to 2**SEL_W, not overridable.
- DWELL, 4, enabled cycles per output in scan mode; must be >= 1.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes all state and holds all outputs.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- load  input  1  scan mode only: jump to s and restart the dwell count.
- s  input  SEL_W  select value.
- a  output  OUT_W  registered one-hot output.
- idx  output  SEL_W  registered index of the set bit in a.
- wrap  output  1  one-cycle pulse when scan steps from OUT_W-1 to 0.

## Operation
- Internal state:
  - idx register.
  - dwell counter, width clog2(DWELL), minimum 1 bit; range 0..DWELL-1.
  - active flag.
- Invariant: once active=1, a == (1 << idx) at all times.
- Reset (rst_n=0, asynchronous):
  - a = 0, idx = 0, wrap = 0.
  - dwell = 0, active = 0.
  - Takes effect immediately, mid-scan included; no partial step completes.
- While active=0, a stays all-zero. The first enabled edge sets active=1 and loads a per the current mode.
- Cycle with en=0: every register holds, including a, idx and dwell. wrap is forced to 0.
- Direct mode (en=1, mode=0):
  - idx <= s, a <= 1 << s, dwell <= 0, wrap <= 0.
  - load is ignored.
- Scan mode (en=1, mode=1). Priority: load, then step, then count.
  - load=1: idx <= s, a <= 1 << s, dwell <= 0, wrap <= 0. A load on a would-be step cycle suppresses that step and its wrap.
  - Step (load=0, dwell == DWELL-1):
    - idx <= idx+1, modulo OUT_W; a <= 1 << (idx+1); dwell <= 0.
    - wrap <= 1 only if idx == OUT_W-1, else 0.
  - Otherwise: dwell <= dwell+1, wrap <= 0, idx and a hold.
- Mode switches:
  - Direct to scan: scan starts from the current idx with dwell = 0, so the first step comes DWELL enabled cycles later.
  - Scan to direct: takes effect on the same edge; dwell is cleared.
- DWELL=1: steps on every enabled scan cycle; the dwell counter stays at 0.

## Timing
- Direct mode: s sampled at edge k appears on a and idx after edge k. Latency is 1 cycle, with no combinational path from s to a.
- Scan mode:
  - a changes exactly every DWELL enabled cycles; en=0 cycles do not count.
  - One full scan period is OUT_W*DWELL enabled cycles.
- wrap is registered and high for exactly one cycle, coincident with a becoming 1 (idx = 0).
- Load takes effect on the same edge with 1-cycle latency. The next step comes DWELL enabled cycles after the load edge.
- Reset deassertion: the first rising edge with rst_n=1 is treated as a normal edge. The design is not required to synchronise rst_n release; that is the integrator's responsibility.

## Test plan
- Reset:
  - Stimulus: rst_n=0 with en=1, mode=0, s=5.
  - Required: a=0x00, idx=0, wrap=0.
  - Then release rst_n: after the first edge, a=0x20 and idx=5.
- Direct sweep:
  - Stimulus: mode=0, en=1, s stepping 0..7, one value per cycle.
  - Required: a follows one cycle later as 0x01, 0x02, 0x04, ... 0x80; wrap stays 0 throughout.
- Scan with wrap (DWELL=4):
  - Stimulus: load with s=6, then hold mode=1, load=0.
  - Required:
    - a=0x40 for 4 cycles, then 0x80 for 4 cycles, then 0x01.
    - wrap=1 only on the cycle a becomes 0x01.
    - Period check: 32 enabled cycles return a to 0x01.
- Enable freeze:
  - Stimulus: in scan mode, drop en for 5 cycles with dwell=2, then restore it.
  - Required: a, idx and dwell hold during the freeze; wrap=0; the step occurs 2 enabled cycles after en returns.
- Load versus step collision:
  - Stimulus: idx=7, dwell=3, load=1 with s=2.
  - Required: a=0x04, idx=2, wrap=0; next step to 0x08 after 4 cycles.
- Asynchronous reset mid-scan:
  - Stimulus: assert rst_n low between clock edges while a=0x10, dwell=2.
  - Required: a=0x00 immediately, with no clock edge needed.
  - After release: with mode=1, the first edge sets a=0x01 and the step to 0x02 comes 4 cycles later.
